// File: rtl/serial_load_pkg.sv
// Shared types and constants for the serial load controller.
// The optional even-parity frame check is enabled with SERIAL_LOAD_PARITY_EN.
package serial_load_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        LOAD   = 2'd3
    } state_t;

    localparam int DEFAULT_DATA_W  = 4;
    localparam int DEFAULT_TIMEOUT = 15;

    // Number of bits needed to encode values 0 .. value-1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/serial_load_timeout.sv
// Inter-bit watchdog: counts consecutive idle cycles inside a frame and
// flags the cycle in which the TIMEOUT-th idle cycle occurs (TIMEOUT=0 disables it).
module serial_load_timeout
    import serial_load_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (clog2(TIMEOUT + 1) < 1) ? 1 : clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT   = CW'(TIMEOUT);
    localparam logic [CW-1:0] PRELAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != LIMIT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Counter saturates at TIMEOUT, so it never wraps back into range.
    assign expired = (TIMEOUT != 0) && enable && !clear && (cnt == PRELAST);

endmodule

// File: rtl/serial_load_ctrl.sv
// Serial-to-parallel load feeder for a 4-bit loadable counter (MSB first).
// Define SERIAL_LOAD_PARITY_EN to require an even-parity bit after the data bits.
module serial_load_ctrl
    import serial_load_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              ser_in,
    input  logic              ser_valid,
    output logic              load,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              err
);

    localparam int BW = clog2(DATA_W + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_d;
    logic [BW-1:0]     bitcnt;
    logic              shreg_en;
    logic              bit_clr;
    logic              data_en;
    logic              err_next;
    logic              in_frame;
    logic              expired;

    assign in_frame = (state == SHIFT) || (state == PARITY);

    serial_load_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (!in_frame || ser_valid),
        .enable  (in_frame && !ser_valid),
        .expired (expired)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        shreg_en   = 1'b0;
        bit_clr    = 1'b0;
        data_en    = 1'b0;
        err_next   = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                    bit_clr    = 1'b1;
                end
            end
            SHIFT: begin
                if (ser_valid) begin
                    shreg_en = 1'b1;
                    if (bitcnt == LAST_BIT) begin
`ifdef SERIAL_LOAD_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = LOAD;
                        data_en    = 1'b1;
`endif
                    end
                end else if (expired) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end
            end
`ifdef SERIAL_LOAD_PARITY_EN
            PARITY: begin
                if (ser_valid) begin
                    // Even parity: data bits plus parity bit must XOR to zero.
                    if (^{shreg, ser_in} == 1'b0) begin
                        state_next = LOAD;
                        data_en    = 1'b1;
                    end else begin
                        state_next = IDLE;
                        err_next   = 1'b1;
                    end
                end else if (expired) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end
            end
`endif
            LOAD: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // data captures the post-shift value, so it is already valid in the LOAD cycle.
    always_comb begin
        shreg_d = shreg;
        if (shreg_en) begin
            shreg_d = {shreg[DATA_W-2:0], ser_in};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            shreg  <= '0;
            bitcnt <= '0;
            data   <= '0;
            err    <= 1'b0;
        end else begin
            state <= state_next;
            shreg <= shreg_d;
            err   <= err_next;
            if (bit_clr) begin
                bitcnt <= '0;
            end else if (shreg_en) begin
                bitcnt <= bitcnt + 1'b1;
            end
            if (data_en) begin
                data <= shreg_d;
            end
        end
    end

    assign load = (state == LOAD);
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_load_ctrl.sv
// Self-checking bench for serial_load_ctrl: directed scenarios plus random
// stimulus compared cycle by cycle against a frame-level reference model.
module tb_serial_load_ctrl;

    localparam int DATA_W  = 4;
    localparam int TIMEOUT = 15;
`ifdef SERIAL_LOAD_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif
    localparam int FRAME_LEN = DATA_W + (PARITY_EN ? 1 : 0);

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              ser_in;
    logic              ser_valid;
    logic              load;
    logic [DATA_W-1:0] data;
    logic              busy;
    logic              err;

    serial_load_ctrl #(
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .ser_in    (ser_in),
        .ser_valid (ser_valid),
        .load      (load),
        .data      (data),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a frame is a list of accepted bits plus an idle-run length.
    bit              m_active;
    bit              m_load;
    bit              m_err;
    int              m_idle;
    bit              m_bits[$];
    logic [DATA_W-1:0] m_data;

    int          cyc;
    int          load_cnt;
    int          load_cyc[$];
    logic [3:0]  ctr_q;

    task automatic model_reset();
        m_active = 1'b0;
        m_load   = 1'b0;
        m_err    = 1'b0;
        m_idle   = 0;
        m_data   = '0;
        m_bits.delete();
    endtask

    task automatic model_step(input logic st, input logic v, input logic b);
        bit new_load;
        bit new_err;
        int val;
        bit par;
        new_load = 1'b0;
        new_err  = 1'b0;
        if (m_load) begin
            // the load cycle always returns to idle; start is ignored while busy
        end else if (!m_active) begin
            if (st) begin
                m_active = 1'b1;
                m_idle   = 0;
                m_bits.delete();
            end
        end else if (v) begin
            m_bits.push_back(b);
            m_idle = 0;
            if (m_bits.size() == FRAME_LEN) begin
                m_active = 1'b0;
                val = 0;
                par = 1'b0;
                for (int i = 0; i < DATA_W; i++) val = val * 2 + int'(m_bits[i]);
                for (int i = 0; i < FRAME_LEN; i++) par = par ^ m_bits[i];
                if (!PARITY_EN || !par) begin
                    new_load = 1'b1;
                    m_data   = DATA_W'(val);
                end else begin
                    new_err = 1'b1;
                end
            end
        end else begin
            m_idle++;
            if (TIMEOUT != 0 && m_idle == TIMEOUT) begin
                m_active = 1'b0;
                new_err  = 1'b1;
            end
        end
        m_load = new_load;
        m_err  = new_err;
    endtask

    // One clock: drive inputs, advance model at the edge, compare at the falling edge.
    task automatic step(input logic st, input logic v, input logic b);
        logic       pre_load;
        logic [3:0] pre_data;
        start     = st;
        ser_valid = v;
        ser_in    = b;
        pre_load  = load;
        pre_data  = data;
        @(posedge clk);
        model_step(st, v, b);
        ctr_q = pre_load ? pre_data : ctr_q + 4'd1;
        @(negedge clk);
        cyc++;
        check("load", load, m_load);
        check("err", err, m_err);
        check("busy", busy, m_active || m_load);
        check("data", data, m_data);
        check("load_err_excl", load & err, 0);
        if (load === 1'b1) begin
            load_cnt++;
            load_cyc.push_back(cyc);
        end
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] v);
        step(1'b1, 1'b0, 1'b0);
        for (int i = DATA_W - 1; i >= 0; i--) step(1'b0, 1'b1, v[i]);
        if (PARITY_EN) step(1'b0, 1'b1, ^v);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [DATA_W-1:0] prev;
        int                n0;
        int                stall;
        reset     = 1'b1;
        start     = 1'b0;
        ser_in    = 1'b0;
        ser_valid = 1'b0;
        cyc       = 0;
        load_cnt  = 0;
        ctr_q     = 4'd0;
        model_reset();

        @(negedge clk);
        @(negedge clk);
        check("rst_load", load, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_data", data, 0);
        reset = 1'b0;

        // Basic frame, then the downstream counter keeps counting from the loaded value.
        send_frame(4'hD);
        check("basic_load", load, 1);
        check("basic_data", data, 4'hD);
        step(1'b0, 1'b0, 1'b0);
        check("ctr_d", ctr_q, 4'hD);
        check("basic_one_cycle", load, 0);
        step(1'b0, 1'b0, 1'b0);
        check("ctr_e", ctr_q, 4'hE);
        step(1'b0, 1'b0, 1'b0);
        check("ctr_f", ctr_q, 4'hF);
        step(1'b0, 1'b0, 1'b0);
        check("ctr_0", ctr_q, 4'h0);

        // Asynchronous reset mid-frame, checked before any clock edge.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("async_load", load, 0);
        check("async_busy", busy, 0);
        check("async_data", data, 0);
        check("async_err", err, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n0 = load_cnt;
        send_frame(4'hA);
        idle(2);
        check("after_rst_data", data, 4'hA);
        check("after_rst_pulses", load_cnt - n0, 1);

        // Timeout boundary: the 15th idle cycle aborts, 14 does not.
        prev = data;
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        idle(TIMEOUT - 1);
        check("to_no_err_early", err, 0);
        check("to_busy_early", busy, 1);
        idle(1);
        check("to_err", err, 1);
        check("to_busy_drop", busy, 0);
        check("to_data_kept", data, prev);
        idle(1);
        check("to_err_pulse", err, 0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        idle(TIMEOUT - 1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        if (PARITY_EN) step(1'b0, 1'b1, 1'b1);
        check("gap_data", data, 4'h7);
        check("gap_load", load, 1);

        // Start/valid collision and start during a frame.
        idle(1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        if (PARITY_EN) step(1'b0, 1'b1, 1'b0);
        check("collide_data", data, 4'h5);
        idle(1);

        // Back-to-back frames at the minimum period.
        send_frame(4'h3);
        check("b2b_data0", data, 4'h3);
        step(1'b0, 1'b0, 1'b0);
        send_frame(4'hC);
        check("b2b_data1", data, 4'hC);
        check("b2b_gap", load_cyc[$] - load_cyc[$-1], FRAME_LEN + 2);
        idle(1);

`ifdef SERIAL_LOAD_PARITY_EN
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        check("par_ok_load", load, 1);
        check("par_ok_data", data, 4'hB);
        idle(1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        check("par_bad_err", err, 1);
        check("par_bad_load", load, 0);
        check("par_bad_data", data, 4'hB);
        idle(1);
`endif

        // Random traffic with occasional long stalls to exercise the watchdog.
        stall = 0;
        for (int i = 0; i < 1500; i++) begin
            logic v;
            if (stall > 0) begin
                v = 1'b0;
                stall--;
            end else begin
                v = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 39) == 0) stall = $urandom_range(10, 18);
            end
            step(($urandom_range(0, 2) == 0), v, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
